// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg: shared FSM encodings and helpers for the MEM-stage bus interface
package mem_bus_if_pkg;
  typedef logic [1:0] mb_state_t;
  localparam logic [1:0] MB_IDLE  = 2'd0;
  localparam logic [1:0] MB_BUSY  = 2'd1;
  localparam logic [1:0] MB_DONE  = 2'd2;
  localparam logic [1:0] MB_DRAIN = 2'd3;
  function automatic logic on_bus(input mb_state_t s);
    return (s == MB_BUSY) || (s == MB_DRAIN);
  endfunction
endpackage

// File: rtl/mem_bus_if_if.sv
// mem_bus_if_if: req/ack wait-state data bus bundle
interface mem_bus_if_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   sel;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;
  logic                  err;
  modport master (output req, we, addr, sel, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_bus_if_timeout_ctr.sv
// mb_timeout_ctr: clear/enable cycle counter flagging the last allowed bus cycle
module mb_timeout_ctr #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // clear wins over count so a fresh access always starts at zero
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + TO_W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign tc_o = cnt_q == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: registers MEM-stage loads/stores onto a req/ack bus and stalls the pipe until done
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic                mem_done_o,
  output logic                err_o,
  output logic                stallreq_o,
  mem_bus_if_if.master        bus
);
  mb_state_t             state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W/8-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tc, active, take, fin, fail, done_now;
  mb_timeout_ctr #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == MB_IDLE),
    .en_i  (active),
    .tc_o  (tc)
  );
  assign active   = on_bus(state_q);
  assign take     = (state_q == MB_IDLE) & mem_ce_i & ~flush_i;
  assign fin      = active & (bus.ack | bus.err | tc);
  assign fail     = bus.err | (tc & ~bus.ack);
  assign done_now = (state_q == MB_BUSY) & fin;
  // next state and request/response register updates; ack/err only matter while on the bus
  always_comb begin
    state_d = take                                     ? MB_BUSY  :
              done_now                                 ? MB_DONE  :
              (state_q == MB_BUSY) & flush_i           ? MB_DRAIN :
              (state_q == MB_DONE) | ((state_q == MB_DRAIN) & fin) ? MB_IDLE : state_q;
    we_d    = take ? mem_we_i   : we_q;
    addr_d  = take ? mem_addr_i : addr_q;
    sel_d   = take ? mem_sel_i  : sel_q;
    wdata_d = take ? mem_data_i : wdata_q;
    rdata_d = done_now ? ((fail | we_q) ? '0 : bus.rdata) : rdata_q;
    err_d   = done_now ? fail : err_q;
  end
  // state and latched request/response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MB_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign bus.req    = active;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.sel    = sel_q;
  assign bus.wdata  = wdata_q;
  assign mem_data_o = rdata_q;
  assign mem_done_o = state_q == MB_DONE;
  assign err_o      = mem_done_o & err_q;
  assign stallreq_o = take | (state_q == MB_BUSY) | ((state_q == MB_DRAIN) & mem_ce_i);
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed stimulus checked against a transaction-level model every cycle
module tb_mem_bus_if;
  localparam int TO = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0, flush = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [3:0]  sel = '0;
  logic        rack = 1'b0, rerr = 1'b0;
  logic [31:0] data_o, data4;
  logic        done_o, err_o, stall_o, done4, err4, stall4;
  int          n_chk = 0, n_fail = 0, n_xfer = 0, n_issue = 0;
  logic        req_prev = 1'b0;
  always #5 clk = ~clk;

  mem_bus_if_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  mem_bus_if_if #(.DATA_W(32), .ADDR_W(32)) bus4 ();
  assign bus.ack = rack;
  assign bus.err = rerr;
  assign bus.rdata = rdata;
  assign bus4.ack = rack;
  assign bus4.err = rerr;
  assign bus4.rdata = rdata;

  mem_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr), .mem_sel_i(sel),
    .mem_data_i(wdata), .flush_i(flush), .mem_data_o(data_o), .mem_done_o(done_o),
    .err_o(err_o), .stallreq_o(stall_o), .bus(bus));
  mem_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4), .TO_W(8)) dut4 (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr), .mem_sel_i(sel),
    .mem_data_i(wdata), .flush_i(flush), .mem_data_o(data4), .mem_done_o(done4),
    .err_o(err4), .stallreq_o(stall4), .bus(bus4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding access, possibly killed by flush, followed by a one-cycle result
  bit          m_busy = 0, m_killed = 0, m_done = 0, m_err = 0, m_we = 0;
  int          m_wait = 0;
  logic [31:0] m_data = '0, m_addr = '0, m_wdata = '0;
  logic [3:0]  m_sel = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_killed = 0; m_done = 0; m_err = 0; m_we = 0; m_wait = 0;
      m_data = '0; m_addr = '0; m_wdata = '0; m_sel = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (rack || rerr || m_wait == TO - 1) begin
        m_busy = 0;
        if (!m_killed) begin
          m_done = 1;
          m_err = rerr || !rack;
          m_data = (m_err || m_we) ? 32'h0 : rdata;
        end
      end else begin
        m_wait++;
        if (flush) m_killed = 1;
      end
    end else if (ce && !flush) begin
      m_busy = 1; m_killed = 0; m_wait = 0;
      m_we = we; m_addr = addr; m_sel = sel; m_wdata = wdata;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = m_busy ? (m_killed ? ce : 1'b1) : m_done ? 1'b0 : (ce & ~flush);
    chk("m_stallreq", stall_o, exp_stall);
    chk("m_bus_req", bus.req, m_busy);
    if (m_busy) begin
      chk("m_bus_addr", bus.addr, m_addr);
      chk("m_bus_sel", bus.sel, m_sel);
      chk("m_bus_we", bus.we, m_we);
      chk("m_bus_wdata", bus.wdata, m_wdata);
    end
    chk("m_done", done_o, m_done);
    chk("m_err", err_o, m_done & m_err);
    chk("m_mem_data", data_o, m_data);
    if (bus.req && (rack || rerr)) n_xfer++;
    if (bus.req && !req_prev) n_issue++;
    req_prev = bus.req;
  end

  task automatic step();
    @(posedge clk);
    #1;
    rack = 1'b0; rerr = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, i0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req", bus.req, 0); chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0); chk("rst_data", data_o, 0);
    rst = 1'b0;
    step();
    // 1: zero-wait load
    ce = 1; we = 0; addr = 32'h100; sel = 4'hF;
    @(negedge clk); chk("t1_stall_idle", stall_o, 1);
    step();
    rack = 1; rdata = 32'hDEADBEEF;
    @(negedge clk); chk("t1_stall_busy", stall_o, 1); chk("t1_addr", bus.addr, 32'h100);
    step();
    ce = 0;
    @(negedge clk);
    chk("t1_done", done_o, 1); chk("t1_data", data_o, 32'hDEADBEEF);
    chk("t1_err", err_o, 0); chk("t1_stall_done", stall_o, 0);
    step();
    // 2: store with three wait states
    x0 = n_xfer;
    ce = 1; we = 1; addr = 32'h204; sel = 4'b0011; wdata = 32'h1234;
    step();
    for (int i = 0; i < 4; i++) begin
      rack = (i == 3);
      @(negedge clk);
      chk("t2_req", bus.req, 1); chk("t2_addr", bus.addr, 32'h204);
      chk("t2_sel", bus.sel, 4'b0011); chk("t2_wdata", bus.wdata, 32'h1234);
      step();
    end
    ce = 0;
    @(negedge clk);
    chk("t2_done", done_o, 1); chk("t2_err", err_o, 0); chk("t2_data", data_o, 0);
    chk("t2_xfers", n_xfer - x0, 1);
    step();
    // 3: timeout on the TIMEOUT=4 instance, then a late ack in its IDLE
    rst = 1; step(); rst = 0;
    ce = 1; we = 0; addr = 32'h40; sel = 4'hF;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t3_req4", bus4.req, 1);
      step();
    end
    ce = 0;
    @(negedge clk);
    chk("t3_done4", done4, 1); chk("t3_err4", err4, 1);
    chk("t3_data4", data4, 0); chk("t3_stall4", stall4, 0);
    step();
    rack = 1; rdata = 32'h55;
    @(negedge clk); chk("t3_late_req4", bus4.req, 0);
    step();
    @(negedge clk);
    chk("t3_late_done4", done4, 0); chk("t3_late_err4", err4, 0);
    chk("t3_main_done", done_o, 1); chk("t3_main_data", data_o, 32'h55);
    step();
    ce = 1; addr = 32'h44;
    step();
    repeat (8) step();
    ce = 0;
    @(negedge clk); chk("t3_main_to_done", done_o, 1); chk("t3_main_to_err", err_o, 1);
    step();
    // 4: flush while BUSY, younger request waits for the drain
    ce = 1; we = 0; addr = 32'h80;
    step();
    @(negedge clk); chk("t4_req", bus.req, 1);
    step();
    flush = 1; addr = 32'h300;
    @(negedge clk); chk("t4_stall_flush", stall_o, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin rack = 1; rdata = 32'h999; end
      @(negedge clk);
      chk("t4_drain_stall", stall_o, 1); chk("t4_drain_done", done_o, 0);
      chk("t4_drain_req", bus.req, 1);
      step();
    end
    @(negedge clk);
    chk("t4_idle_done", done_o, 0); chk("t4_idle_req", bus.req, 0); chk("t4_idle_stall", stall_o, 1);
    step();
    rack = 1; rdata = 32'hA5;
    @(negedge clk); chk("t4_new_addr", bus.addr, 32'h300);
    step();
    ce = 0;
    @(negedge clk); chk("t4_done", done_o, 1); chk("t4_data", data_o, 32'hA5);
    step();
    // 5: back-to-back loads
    x0 = n_xfer; i0 = n_issue;
    ce = 1; addr = 32'h0;
    step();
    rack = 1; rdata = 32'h11;
    @(negedge clk); chk("t5_addr0", bus.addr, 32'h0);
    step();
    addr = 32'h4;
    @(negedge clk); chk("t5_done0", done_o, 1); chk("t5_data0", data_o, 32'h11); chk("t5_stall_done", stall_o, 0);
    step();
    @(negedge clk); chk("t5_idle_req", bus.req, 0); chk("t5_idle_stall", stall_o, 1);
    step();
    rack = 1; rdata = 32'h22;
    @(negedge clk); chk("t5_addr4", bus.addr, 32'h4);
    step();
    ce = 0;
    @(negedge clk);
    chk("t5_done4", done_o, 1); chk("t5_data4", data_o, 32'h22);
    chk("t5_issues", n_issue - i0, 2); chk("t5_xfers", n_xfer - x0, 2);
    step();
    // 6: reset mid-BUSY, then ack and err together
    ce = 1; we = 1; addr = 32'h500; sel = 4'hF; wdata = 32'hAB;
    step();
    rst = 1; ce = 0;
    @(negedge clk); chk("t6_req_pre", bus.req, 1);
    step();
    @(negedge clk);
    chk("t6_req", bus.req, 0); chk("t6_addr", bus.addr, 0); chk("t6_sel", bus.sel, 0);
    chk("t6_we", bus.we, 0); chk("t6_wdata", bus.wdata, 0); chk("t6_stall", stall_o, 0);
    chk("t6_done", done_o, 0); chk("t6_err", err_o, 0); chk("t6_data", data_o, 0);
    rst = 0;
    step();
    ce = 1; we = 0; addr = 32'h600;
    step();
    rack = 1; rerr = 1; rdata = 32'hFFFF;
    step();
    ce = 0;
    @(negedge clk); chk("t6_both_err", err_o, 1); chk("t6_both_done", done_o, 1); chk("t6_both_data", data_o, 0);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
